// File: rtl/adsb_ppm_encoder.sv
// ADS-B extended-squitter PPM transmitter: 8 us preamble + 112 x 1 us bit windows, Q8 slot timing.
// Define ADSB_ENC_CRC_EN to replace bits 88..111 with a Mode S CRC-24 computed on the fly.
module adsb_ppm_encoder #(
    parameter int MSG_BITS   = 112,
    parameter int HALF_US_Q8 = 7864,
    parameter int PRE_SLOTS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MSG_BITS-1:0] message_bits,
    input  logic                message_start,
    output logic                adsb_pulse,
    output logic                busy,
    output logic                done
);
    localparam int TOTAL_SLOTS = PRE_SLOTS + 2 * MSG_BITS;
    localparam int SLOT_W      = $clog2(TOTAL_SLOTS);
    localparam int BIT_W       = $clog2(MSG_BITS);
    localparam logic [15:0]       HALF_Q8     = 16'(HALF_US_Q8);
    localparam logic [15:0]       PRE_PATTERN = 16'h0285;  // bit i = level of preamble slot i
    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(TOTAL_SLOTS - 1);
    localparam logic [SLOT_W-1:0] PRE_LAST    = SLOT_W'(PRE_SLOTS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREAMBLE = 2'd1;
    localparam logic [1:0] DATA     = 2'd2;

    logic [1:0]          state_reg, state_next;
    logic [7:0]          frac_reg, frac_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [SLOT_W-1:0]   slot_reg, slot_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic                half_reg, half_next;
    logic [MSG_BITS-1:0] shift_reg, shift_next;
    logic                pulse_reg, pulse_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic [15:0]         acc_sum;
    logic                tx_new;

`ifdef ADSB_ENC_CRC_EN
    localparam logic [BIT_W-1:0] CRC_START = BIT_W'(MSG_BITS - 24);
    localparam logic [23:0]      CRC_POLY  = 24'hFFF409;
    logic [23:0] crc_reg, crc_next;
    logic        tx_cur;
`endif

    always_comb begin
        state_next = state_reg;
        frac_next  = frac_reg;
        cnt_next   = cnt_reg;
        slot_next  = slot_reg;
        bit_next   = bit_reg;
        half_next  = half_reg;
        shift_next = shift_reg;
        pulse_next = pulse_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        acc_sum    = {8'd0, frac_reg} + HALF_Q8;
        tx_new     = 1'b0;
`ifdef ADSB_ENC_CRC_EN
        crc_next = crc_reg;
        tx_cur   = (bit_reg >= CRC_START) ? crc_reg[23] : shift_reg[MSG_BITS-1];
`endif
        case (state_reg)
            IDLE: begin
                // The done cycle still blocks a new start, so re-accept is one cycle later.
                if (message_start && !done_reg) begin
                    state_next = PREAMBLE;
                    frac_next  = HALF_Q8[7:0];
                    cnt_next   = HALF_Q8[15:8] - 8'd1;
                    slot_next  = '0;
                    bit_next   = '0;
                    half_next  = 1'b0;
                    shift_next = message_bits;
                    pulse_next = PRE_PATTERN[0];
                    busy_next  = 1'b1;
`ifdef ADSB_ENC_CRC_EN
                    crc_next = '0;
`endif
                end
            end
            default: begin
                if (cnt_reg == 8'd0) begin
                    if (slot_reg == LAST_SLOT) begin
                        state_next = IDLE;
                        frac_next  = '0;
                        slot_next  = '0;
                        bit_next   = '0;
                        half_next  = 1'b0;
                        pulse_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        frac_next = acc_sum[7:0];
                        cnt_next  = acc_sum[15:8] - 8'd1;
                        slot_next = slot_reg + SLOT_W'(1);
                        if (state_reg == DATA) begin
                            half_next = ~half_reg;
                            if (half_reg) begin
                                shift_next = shift_reg << 1;
                                bit_next   = bit_reg + BIT_W'(1);
`ifdef ADSB_ENC_CRC_EN
                                if (bit_reg < CRC_START)
                                    crc_next = {crc_reg[22:0], 1'b0} ^
                                               ((tx_cur ^ crc_reg[23]) ? CRC_POLY : 24'd0);
                                else
                                    crc_next = {crc_reg[22:0], 1'b0};
`endif
                            end
                        end else if (slot_reg == PRE_LAST) begin
                            state_next = DATA;
                            half_next  = 1'b0;
                        end
                        tx_new = shift_next[MSG_BITS-1];
`ifdef ADSB_ENC_CRC_EN
                        if (bit_next >= CRC_START)
                            tx_new = crc_next[23];
`endif
                        if (state_next == DATA)
                            pulse_next = half_next ? ~tx_new : tx_new;
                        else
                            pulse_next = PRE_PATTERN[slot_next[3:0]];
                    end
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            frac_reg  <= '0;
            cnt_reg   <= '0;
            slot_reg  <= '0;
            bit_reg   <= '0;
            half_reg  <= 1'b0;
            shift_reg <= '0;
            pulse_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            frac_reg  <= frac_next;
            cnt_reg   <= cnt_next;
            slot_reg  <= slot_next;
            bit_reg   <= bit_next;
            half_reg  <= half_next;
            shift_reg <= shift_next;
            pulse_reg <= pulse_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

`ifdef ADSB_ENC_CRC_EN
    always_ff @(posedge clk) begin
        if (rst) crc_reg <= '0;
        else     crc_reg <= crc_next;
    end
`endif

    assign adsb_pulse = pulse_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
endmodule

// File: tb/tb_adsb_ppm_encoder.sv
// Self-checking bench for adsb_ppm_encoder: table-driven frames, scoreboard of expected payloads.
module tb_adsb_ppm_encoder;
    localparam int FRAME = 7372;
    localparam int LOGN  = 7400;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [111:0] message_bits = '0;
    logic         message_start = 1'b0;
    logic         adsb_pulse, busy, done;

    adsb_ppm_encoder dut (
        .clk(clk), .rst(rst), .message_bits(message_bits), .message_start(message_start),
        .adsb_pulse(adsb_pulse), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [111:0] msg;
        logic [111:0] exp;
    } vec_t;

    vec_t         vecs[4];
    logic [111:0] sb_q[$];
    int           slot_start[241];
    int           slot_of[FRAME];
    logic         pulse_log[LOGN];
    logic         busy_log[LOGN];
    logic         done_log[LOGN];
    logic [15:0]  pre_pat = 16'b1010000101000000;
    int           check_count = 0;
    int           pass_count = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        check_count++;
        if (act === req) pass_count++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [23:0] crc24(input logic [87:0] d);
        logic [23:0] c = '0;
        for (int i = 87; i >= 0; i--) begin
            logic fb = d[i] ^ c[23];
            c = {c[22:0], 1'b0} ^ (fb ? 24'hFFF409 : 24'h0);
        end
        return c;
    endfunction

    function automatic logic model_pulse(input int c, input logic [111:0] tx);
        int k, b;
        if (c >= FRAME) return 1'b0;
        k = slot_of[c];
        if (k < 16) return pre_pat[15-k];
        b = (k - 16) / 2;
        return (((k - 16) % 2) == 0) ? tx[111-b] : ~tx[111-b];
    endfunction

    task automatic send(input logic [111:0] msg, input logic [111:0] exp);
        @(negedge clk);
        message_bits  = msg;
        message_start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        message_start = 1'b0;
    endtask

    // Entered at the negedge of frame cycle 0; records through cycle 'last' and checks the frame.
    task automatic capture(input string tag, input int last, input int mid_at, input logic [111:0] mid_msg,
                           input int chain_at, input logic [111:0] chain_msg);
        logic [111:0] exp, got;
        int wave_err = 0, busy_err = 0, done_err = 0, first_err = -1, busy_len = 0;
        int rises[$];
        int first_data_rise = -1;
        logic [127:0] pre_act;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        for (int c = 0; c <= last; c++) begin
            pulse_log[c] = adsb_pulse;
            busy_log[c]  = busy;
            done_log[c]  = done;
            if (mid_at >= 0 && c == mid_at) begin message_bits = mid_msg; message_start = 1'b1; end
            if (mid_at >= 0 && c == mid_at + 1) message_start = 1'b0;
            if (chain_at >= 0 && c == chain_at) begin message_bits = chain_msg; message_start = 1'b1; end
            if (c < last) @(negedge clk);
        end
        for (int c = 0; c <= last; c++) begin
            if (pulse_log[c] !== model_pulse(c, exp)) begin
                wave_err++;
                if (first_err < 0) first_err = c;
            end
            if (busy_log[c] !== (c < FRAME)) busy_err++;
            if (done_log[c] !== (c == FRAME)) done_err++;
            if (busy_log[c] === 1'b1) busy_len++;
            if (pulse_log[c] && (c == 0 || !pulse_log[c-1])) begin
                if (c < 491) rises.push_back(c);
                else if (first_data_rise < 0) first_data_rise = c;
            end
        end
        for (int b = 0; b < 112; b++) begin
            int s = 16 + 2 * b;
            got[111-b] = pulse_log[(slot_start[s] + slot_start[s+1]) / 2];
        end
        pre_act = {8'(rises.size()),
                   24'((rises.size() > 0) ? rises[0] : -1), 24'((rises.size() > 1) ? rises[1] : -1),
                   24'((rises.size() > 2) ? rises[2] : -1), 24'((rises.size() > 3) ? rises[3] : -1)};
        check({tag, " wave_mismatches"}, 128'(wave_err), 128'd0);
        check({tag, " busy_len"}, 128'(busy_len), 128'(FRAME));
        check({tag, " busy_profile"}, 128'(busy_err), 128'd0);
        check({tag, " done_profile"}, 128'(done_err), 128'd0);
        check({tag, " preamble_rises"}, pre_act, {8'd4, 24'd0, 24'd61, 24'd215, 24'd276});
        check({tag, " decoded_bits"}, 128'(got), 128'(exp));
        if (exp == '0) check({tag, " first_data_rise"}, 128'(first_data_rise), 128'd522);
        $display("frame %s: expected %h decoded %h busy %0d cycles first_wave_err %0d",
                 tag, exp, got, busy_len, first_err);
    endtask

    initial begin
        int hi_p, hi_b, hi_d;
        logic [111:0] rnd;
        for (int k = 0; k <= 240; k++) slot_start[k] = (k * 7864) / 256;
        for (int k = 0; k < 240; k++)
            for (int c = slot_start[k]; c < slot_start[k+1]; c++) slot_of[c] = k;

        rnd = 112'h5DA3C17F029BE411C06A3FD258;
        vecs[0].msg = '0;
        vecs[0].exp = '0;
        vecs[1].msg = 112'h8D4840D6202CC371C32CE0576098;
        vecs[1].exp = 112'h8D4840D6202CC371C32CE0576098;
        vecs[2].msg = 112'h8D4840D6202CC371C32CE0000000;
`ifdef ADSB_ENC_CRC_EN
        vecs[2].exp = 112'h8D4840D6202CC371C32CE0576098;
        vecs[3].exp = {rnd[111:24], crc24(rnd[111:24])};
`else
        vecs[2].exp = 112'h8D4840D6202CC371C32CE0000000;
        vecs[3].exp = rnd;
`endif
        vecs[3].msg = rnd;

        repeat (3) @(negedge clk);
        check("reset pulse", 128'(adsb_pulse), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        rst = 1'b0;
        hi_p = 0; hi_b = 0; hi_d = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            hi_p += int'(adsb_pulse); hi_b += int'(busy); hi_d += int'(done);
        end
        check("idle pulse_high", 128'(hi_p), 128'd0);
        check("idle busy_high", 128'(hi_b), 128'd0);
        check("idle done_high", 128'(hi_d), 128'd0);
        $display("idle: 100 cycles pulse_high %0d busy_high %0d done_high %0d", hi_p, hi_b, hi_d);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].msg, vecs[i].exp);
            capture($sformatf("vec%0d", i), FRAME + 20, -1, '0, -1, '0);
        end

        // Start at cycle 1000 must be ignored; start held across done is accepted one cycle later.
        send(vecs[1].msg, vecs[1].exp);
        sb_q.push_back(vecs[3].exp);
        capture("ignore_mid", FRAME + 1, 1000, 112'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, FRAME, vecs[3].msg);
        @(negedge clk);
        message_start = 1'b0;
        capture("back_to_back", FRAME + 20, -1, '0, -1, '0);

        send(vecs[3].msg, vecs[3].exp);
        for (int c = 0; c < 3000; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort pulse", 128'(adsb_pulse), 128'd0);
        check("abort busy", 128'(busy), 128'd0);
        check("abort done", 128'(done), 128'd0);
        rst = 1'b0;
        void'(sb_q.pop_front());
        hi_d = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hi_d += int'(done) + int'(busy);
        end
        check("abort quiet", 128'(hi_d), 128'd0);
        $display("abort: reset at frame cycle 3000, outputs pulse %0d busy %0d done %0d", adsb_pulse, busy, done);
        send(vecs[2].msg, vecs[2].exp);
        capture("after_reset", FRAME + 20, -1, '0, -1, '0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
